// File: rtl/nibble_serial_adder16.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder16
//
// Purpose:
//   16-bit adder/subtractor that processes its operands one 4-bit nibble per
//   clock, LSB nibble first. Each nibble goes through a 4-bit carry-lookahead
//   slice. The carry out of one nibble is registered and fed into the next.
//   An operation takes one accept cycle, four RUN cycles and one DONE cycle,
//   so a new operation can start at most once every six cycles.
//
// Ports:
//   clk    in   1   clock; all state changes on the rising edge
//   rst_n  in   1   synchronous active-low reset
//   start  in   1   operation request, sampled only while idle
//   sub    in   1   0 = a + b + cin, 1 = a - b (cin ignored)
//   a      in  16   operand A, captured on an accepted start
//   b      in  16   operand B, captured on an accepted start
//   cin    in   1   carry-in for add, captured on an accepted start
//   ready  out  1   high only while idle
//   done   out  1   one-cycle pulse when sum/cout/ovf are valid
//   sum    out 16   result, held until the next operation runs
//   cout   out  1   carry out of bit 15
//   ovf    out  1   signed two's-complement overflow
// -----------------------------------------------------------------------------
module nibble_serial_adder16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sub,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic        ready,
    output logic        done,
    output logic [15:0] sum,
    output logic        cout,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [1:0]  cnt_q;
    logic        carry_q;
    logic [15:0] op_a_q;
    logic [15:0] op_b_q;
    logic [15:0] sum_q;
    logic        cout_q;
    logic        ovf_q;

    logic        accept;
    logic        run_step;
    logic        last_nibble;

    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [3:0]  nib_sum;
    logic        nib_cout;
    logic [15:0] sum_next;

    // 4-bit carry-lookahead slice. Every carry is written out directly from
    // the generate/propagate terms and the incoming carry, so none of them
    // ripples through the previous bit's carry.
    // Returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] cla4(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       c0
    );
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Next-state logic and FSM-decoded outputs.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        run_step    = 1'b0;
        last_nibble = 1'b0;
        ready       = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                run_step = 1'b1;
                if (cnt_q == 2'd3) begin
                    last_nibble = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pick the operand nibble selected by the counter.
    always_comb begin
        nib_a = 4'h0;
        nib_b = 4'h0;
        case (cnt_q)
            2'd0: begin nib_a = op_a_q[3:0];   nib_b = op_b_q[3:0];   end
            2'd1: begin nib_a = op_a_q[7:4];   nib_b = op_b_q[7:4];   end
            2'd2: begin nib_a = op_a_q[11:8];  nib_b = op_b_q[11:8];  end
            2'd3: begin nib_a = op_a_q[15:12]; nib_b = op_b_q[15:12]; end
            default: begin nib_a = 4'h0; nib_b = 4'h0; end
        endcase
    end

    always_comb begin
        {nib_cout, nib_sum} = cla4(nib_a, nib_b, carry_q);
    end

    // The current result with the nibble being computed merged in. The
    // overflow check on the last nibble needs the new bit 15, not the old one.
    always_comb begin
        sum_next = sum_q;
        case (cnt_q)
            2'd0: sum_next[3:0]   = nib_sum;
            2'd1: sum_next[7:4]   = nib_sum;
            2'd2: sum_next[11:8]  = nib_sum;
            2'd3: sum_next[15:12] = nib_sum;
            default: sum_next = sum_q;
        endcase
    end

    // Datapath registers. Subtraction is folded into the capture: b is
    // inverted and the carry register starts at 1, so RUN only ever adds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            carry_q <= 1'b0;
            op_a_q  <= 16'h0000;
            op_b_q  <= 16'h0000;
            sum_q   <= 16'h0000;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            op_a_q  <= a;
            op_b_q  <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= 2'd0;
        end else if (run_step) begin
            sum_q   <= sum_next;
            carry_q <= nib_cout;
            cnt_q   <= cnt_q + 2'd1;
            if (last_nibble) begin
                cout_q <= nib_cout;
                ovf_q  <= (op_a_q[15] == op_b_q[15]) &&
                          (sum_next[15] != op_a_q[15]);
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder16.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder16
//
// Purpose:
//   Self-checking bench for nibble_serial_adder16 using directed vectors
//   whose expected results were worked out by hand.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        ready;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int vectors;
    int miscompares;

    nibble_serial_adder16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h",
                     tag, observed, expected);
        end
    endtask

    // One complete operation. Inputs are driven on falling edges and outputs
    // are sampled on falling edges. The edge that accepts the start is E0.
    task automatic applyStimulus(input string tag, input logic [15:0] va,
                                 input logic [15:0] vb, input logic vsub,
                                 input logic vcin, input logic [15:0] exp_sum,
                                 input logic exp_cout, input logic exp_ovf);
        int waited;
        waited = 0;
        while (!ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, "_ready"}, 32'(ready), 32'd1);
        a     = va;
        b     = vb;
        sub   = vsub;
        cin   = vcin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, "_busy"}, 32'(ready), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checkOutput({tag, "_early_done"}, 32'(done), 32'd0);
        end
        @(negedge clk);
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        checkOutput({tag, "_cout"}, 32'(cout), 32'(exp_cout));
        checkOutput({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
        checkOutput({tag, "_idle"}, 32'(ready), 32'd1);
        checkOutput({tag, "_held"}, 32'(sum), 32'(exp_sum));
    endtask

    initial begin
        int pulses;
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        start = 1'b1;
        sub   = 1'b0;
        a     = 16'h1111;
        b     = 16'h2222;
        cin   = 1'b0;

        // Reset, with start asserted during it; the start must not be taken.
        repeat (3) @(negedge clk);
        checkOutput("rst_sum", 32'(sum), 32'h0);
        checkOutput("rst_cout", 32'(cout), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_ready", 32'(ready), 32'd1);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_no_accept", 32'(ready), 32'd1);

        applyStimulus("add",     16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        applyStimulus("ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        applyStimulus("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        applyStimulus("sub",     16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        applyStimulus("add_cin", 16'h00FF, 16'h0F00, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0);

        // Start during RUN with different operands is ignored.
        a = 16'h1234; b = 16'h4321; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; sub = 1'b1; cin = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i < 4) checkOutput("ign_ready", 32'(ready), 32'd0);
            if (done) pulses++;
        end
        start = 1'b0;
        checkOutput("ign_sum", 32'(sum), 32'h5555);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checkOutput("ign_pulses", 32'(pulses), 32'd1);

        // Reset during RUN, asserted at the edge after nibble 1.
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abort_sum", 32'(sum), 32'h0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_ready", 32'(ready), 32'd1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checkOutput("abort_no_done", 32'(pulses), 32'd0);
        applyStimulus("after_abort", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

        // Start held high: one operation every six cycles.
        a = 16'h0001; b = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
        pulses = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        start = 1'b0;
        checkOutput("stream_pulses", 32'(pulses), 32'd3);
        checkOutput("stream_sum", 32'(sum), 32'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder16.md
NIBBLE_SERIAL_ADDER16 -- requirements
Module: nibble_serial_adder16

Interface
REQ-001 Parameters: none; width fixed at 16 bits, processed as four 4-bit nibbles.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request an operation; sampled only in IDLE.
REQ-005 sub  input  1  0 = add (a + b + cin); 1 = subtract (a + ~b + 1, cin ignored).
REQ-006 a  input  16  operand A; captured on an accepted start.
REQ-007 b  input  16  operand B; captured on an accepted start.
REQ-008 cin  input  1  carry-in for add; captured on an accepted start.
REQ-009 ready  output  1  high only in IDLE.
REQ-010 done  output  1  one-cycle pulse when the result is valid.
REQ-011 sum  output  16  result; held until the next accepted start.
REQ-012 cout  output  1  carry out of bit 15; held with sum.
REQ-013 ovf  output  1  signed two's-complement overflow; held with sum.

Function
REQ-014 FSM states: IDLE, RUN, DONE.
- IDLE->RUN on start=1.
- RUN->RUN while nibble counter < 3.
- RUN->DONE after nibble 3.
- DONE->IDLE unconditionally.
REQ-015 Accepted start (IDLE, start=1) captures:
- a into op_a;
- (sub ? ~b : b) into op_b;
- (sub ? 1 : cin) into the carry register;
- clears the nibble counter.
REQ-016 Each RUN cycle, nibble k (k = counter, 0..3, LSB first) is computed by a 4-bit carry-lookahead slice: generate g = a&b, propagate p = a^b, carries from g/p/carry, sum = p ^ carry vector.
REQ-017 Each RUN cycle writes the slice sum into sum[4k+3:4k], loads the slice carry-out into the carry register, and increments the counter.
REQ-018 Latency: start accepted at edge E0. Nibbles 0..3 are computed at edges E1..E4. done=1 in the cycle following E4. ready=1 again in the cycle following E5.
REQ-019 On the nibble-3 edge:
- cout = slice carry-out;
- ovf = (op_a[15] == op_b[15]) && (new sum[15] != op_a[15]).
REQ-020 done is high only in DONE, for exactly one cycle per accepted start.
REQ-021 start is ignored in RUN and DONE; captured operands do not change mid-operation.
REQ-022 start held high continuously: a new operation is accepted on every IDLE cycle, i.e. one per 6 cycles.
REQ-023 sum, cout and ovf change only during RUN or on reset.
- Partial nibbles may be visible during RUN.
- Consumers sample on done.
REQ-024 Arithmetic is modulo 2^16; wrap-around is reported only through cout and ovf.

Reset
REQ-025 While rst_n=0 at a rising edge, all registers are reset:
- state = IDLE, counter = 0, carry = 0;
- sum = 0x0000, cout = 0, ovf = 0, done = 0;
- ready = 1 in the following cycle.
REQ-026 Reset asserted in RUN or DONE aborts the operation: no done pulse, partial result discarded, outputs cleared per REQ-025.
REQ-027 start coincident with rst_n=0 is not accepted.

Verification
REQ-028 Add: a=0x1234, b=0x4321, sub=0, cin=0 -> done 5 cycles after the accept edge; sum=0x5555, cout=0, ovf=0.
REQ-029 Carry ripple across nibbles: a=0xFFFF, b=0x0001, sub=0, cin=0 -> sum=0x0000, cout=1, ovf=0.
REQ-030 Signed overflow:
- add a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, cout=0;
- sub a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1, cout=1.
REQ-031 Subtract: a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0 (cin ignored).
REQ-032 Start during RUN with different operands -> ignored; first result unchanged; exactly one done pulse; ready low until after DONE.
REQ-033 Reset mid-operation:
- rst_n=0 at the edge after nibble 1 -> next cycle sum=0x0000, done=0, ready=1;
- no done pulse for the aborted operation;
- a new start then completes normally.
